// File: rtl/serial_sub8_pkg.sv
// Shared ALU constants for the bit-serial subtractor: FSM encodings and default width.
package serial_sub8_pkg;

    localparam int unsigned ALU_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/sub_bit_cell.sv
// 1-bit full subtractor: d = a - b - bi, bo = borrow out.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | ((~a | b) & bi);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial W-bit subtractor: one sub_bit_cell, borrow held in a flop, LSB first.
// Result and flags are registered and announced with a one-cycle done pulse.
module serial_sub8
    import serial_sub8_pkg::*;
#(
    parameter int unsigned W = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    // Only the upper W-1 result bits are kept; the final bit comes straight from the cell.
    logic [W-2:0]    sr_q, sr_d;
    logic            br_q, br_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            msb_a_q, msb_a_d;
    logic            msb_b_q, msb_b_d;
    logic [W-1:0]    diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            zero_q, zero_d;
    logic            ovf_q, ovf_d;

    logic cell_d, cell_bo;

    sub_bit_cell u_cell (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .bi (br_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        msb_a_d = msb_a_q;
        msb_b_d = msb_b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    msb_a_d = a[W-1];
                    msb_b_d = b[W-1];
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                br_d  = cell_bo;
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = (W-1)'({cell_d, sr_q} >> 1);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    diff_d  = {cell_d, sr_q};
                    bout_d  = cell_bo;
                    zero_d  = ({cell_d, sr_q} == '0);
                    ovf_d   = (msb_a_q ^ msb_b_q) & (cell_d ^ msb_a_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready = (state_q == S_IDLE);
    assign done  = (state_q == S_DONE);
    assign diff  = diff_q;
    assign bout  = bout_q;
    assign zero  = zero_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Directed-vector bench for serial_sub8 (W=8) with hand-computed expected results.
module tb_serial_sub8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       ready;
    logic       done;
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    logic       ovf;

    int n_checks = 0;
    int n_pass   = 0;

    serial_sub8 #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One operation; poke >= 1 re-asserts start with other operands after that many edges.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic binv, input logic [7:0] ed, input logic eb,
                          input logic ez, input logic eo, input int poke);
        int   edges;
        logic seen;
        logic ready_high;
        @(negedge clk);
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        bin   = 1'($urandom);
        edges = 1;
        seen  = 1'b0;
        ready_high = 1'b0;
        check({tag, "_ready_drop"}, {31'd0, ready}, 32'd0);
        while (!seen && edges < 20) begin
            if (edges == poke) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (ready) ready_high = 1'b1;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, edges, 32'd9);
        check({tag, "_ready_busy"}, {31'd0, ready_high}, 32'd0);
        check({tag, "_diff"}, {24'd0, diff}, {24'd0, ed});
        check({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
        check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
        check({tag, "_diff_hold"}, {24'd0, diff}, {24'd0, ed});
    endtask

    initial begin
        logic done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        bin   = 1'b0;
        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_diff", {24'd0, diff}, 32'd0);
        check("rst_flags", {29'd0, bout, zero, ovf}, 32'd0);

        // Release after an edge so the next edge is the first with rst_n=1.
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, -1);
        run_op("sub_03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, -1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1, -1);
        run_op("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1, -1);
        run_op("sub_10_0f_b", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, -1);
        run_op("ignore_start", 8'h20, 8'h01, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0, 3);

        // Abort mid-SHIFT with reset after the 4th shift edge.
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h11;
        bin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_diff", {24'd0, diff}, 32'd0);
        check("abort_flags", {29'd0, bout, zero, ovf}, 32'd0);
        done_seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) done_seen = 1'b1;
        end
        check("abort_no_done", {31'd0, done_seen}, 32'd0);

        run_op("after_abort", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
